// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: word-level valid/ready request channel between a requester and the data-memory arbiter.
interface dmem_arbiter_if #(parameter int AW = 32);
  logic valid;
  logic write;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic ready;
  logic done;
  logic [31:0] rdata;
  logic err;
  modport master(output valid, write, addr, wdata, input ready, done, rdata, err);
  modport slave(input valid, write, addr, wdata, output ready, done, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port word access sequenced as four big-endian byte accesses on a byte RAM.
// Optional DMEM_ALIGN_CHECK_EN: unaligned word addresses are rejected with err.
module dmem_arbiter #(
  parameter int DEPTH = 36,
  parameter int AW = 32
) (
  input  logic clk,
  input  logic reset,
  dmem_arbiter_if.slave req0,
  dmem_arbiter_if.slave req1,
  output logic [AW-1:0] mem_addr,
  output logic mem_we,
  output logic mem_re,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
  state_t state;
  logic [1:0] cnt;
  logic gnt, wr, bad, we_r, re_r, sel, take, bad_in, w_in;
  logic [23:0] wbuf, rbuf;
  logic [AW-1:0] a_in;
  logic [31:0] d_in;
  // gnt remembers the last granted port; it also steers the done/rdata of the current access
  assign req0.ready = reset && state == IDLE && req0.valid && (!req1.valid || gnt);
  assign req1.ready = reset && state == IDLE && req1.valid && (!req0.valid || !gnt);
  assign sel = req1.ready;
  assign take = req0.ready || req1.ready;
  assign a_in = sel ? req1.addr : req0.addr;
  assign d_in = sel ? req1.wdata : req0.wdata;
  assign w_in = sel ? req1.write : req0.write;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_in = a_in > AW'(DEPTH - 4) || a_in[1:0] != 2'b00;
`else
  assign bad_in = a_in > AW'(DEPTH - 4);
`endif
  // strobes drop in the very cycle reset is asserted so an aborted store stops at once
  assign mem_we = we_r && reset;
  assign mem_re = re_r && reset;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 2'd0;
      gnt <= 1'b1;
      wr <= 1'b0;
      bad <= 1'b0;
      we_r <= 1'b0;
      re_r <= 1'b0;
      wbuf <= 24'h0;
      rbuf <= 24'h0;
      mem_addr <= '0;
      mem_wdata <= 8'h00;
      req0.done <= 1'b0;
      req1.done <= 1'b0;
      req0.err <= 1'b0;
      req1.err <= 1'b0;
      req0.rdata <= 32'h0;
      req1.rdata <= 32'h0;
    end else begin
      req0.done <= 1'b0;
      req1.done <= 1'b0;
      req0.err <= 1'b0;
      req1.err <= 1'b0;
      case (state)
        IDLE: if (take) begin
          state <= XFER;
          cnt <= 2'd0;
          gnt <= sel;
          wr <= w_in;
          bad <= bad_in;
          we_r <= !bad_in && w_in;
          re_r <= !bad_in && !w_in;
          mem_addr <= a_in;
          mem_wdata <= d_in[31:24];
          wbuf <= d_in[23:0];
        end
        XFER: if (bad) begin
          state <= DONE;
          req0.done <= !gnt;
          req1.done <= gnt;
          req0.err <= !gnt;
          req1.err <= gnt;
        end else begin
          cnt <= cnt + 2'd1;
          rbuf <= {rbuf[15:0], mem_rdata};
          if (cnt == 2'd3) begin
            state <= DRAIN;
            we_r <= 1'b0;
            re_r <= 1'b0;
          end else begin
            mem_addr <= mem_addr + AW'(1);
            mem_wdata <= wbuf[23:16];
            wbuf <= {wbuf[15:0], 8'h00};
          end
        end
        DRAIN: begin
          state <= DONE;
          req0.done <= !gnt;
          req1.done <= gnt;
          if (!wr && gnt) req1.rdata <= {rbuf, mem_rdata};
          if (!wr && !gnt) req0.rdata <= {rbuf, mem_rdata};
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a cycle-offset reference model of the arbiter.
module tb_dmem_arbiter;
  localparam int DEPTH = 36;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] mem_addr;
  logic mem_we, mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [64];
  logic [7:0] ref_mem [64];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dmem_arbiter_if #(.AW(32)) i0();
  dmem_arbiter_if #(.AW(32)) i1();

  dmem_arbiter #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset), .req0(i0), .req1(i1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[5:0]];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a > 32'(DEPTH - 4) || a[1:0] != 2'b00;
`else
    return a > 32'(DEPTH - 4);
`endif
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[a[5:0]], ref_mem[a[5:0] + 6'd1], ref_mem[a[5:0] + 6'd2], ref_mem[a[5:0] + 6'd3]};
  endfunction

  // Reference model: one outstanding access, timed by offset from its grant cycle.
  bit busy = 1'b0, g_port = 1'b0, g_bad = 1'b0, g_write = 1'b0, last = 1'b1;
  int g_cyc = -100;
  logic [31:0] g_addr = 0, g_wdata = 0, exp_rd0 = 0, exp_rd1 = 0;

  always @(negedge clk) begin : model
    int d, lim;
    bit ed0, ed1, ee, er0, er1, ere, ewe, free;
    logic [31:0] ea;
    logic [7:0] ewd;
    d = cyc - g_cyc;
    lim = g_bad ? 2 : 6;
    ed0 = 0; ed1 = 0; ee = 0; ere = 0; ewe = 0; ea = 0; ewd = 0;
    if (busy && !g_bad && d >= 1 && d <= 4 && reset) begin
      ere = !g_write;
      ewe = g_write;
      ea = g_addr + 32'(d - 1);
      ewd = 8'(g_wdata >> (8 * (4 - d)));
    end
    if (busy && d == lim) begin
      ed0 = !g_port;
      ed1 = g_port;
      ee = g_bad;
      if (!g_bad && !g_write) begin
        if (g_port) exp_rd1 = ref_word(g_addr);
        else exp_rd0 = ref_word(g_addr);
      end
    end
    free = !busy || d > lim;
    er0 = reset && free && i0.valid && (!i1.valid || last);
    er1 = reset && free && i1.valid && (!i0.valid || !last);
    chk("ready0", i0.ready, er0);
    chk("ready1", i1.ready, er1);
    chk("done0", i0.done, ed0);
    chk("done1", i1.done, ed1);
    chk("rdata0", i0.rdata, exp_rd0);
    chk("rdata1", i1.rdata, exp_rd1);
    chk("mem_re", mem_re, ere);
    chk("mem_we", mem_we, ewe);
    if (ere || ewe) chk("mem_addr", mem_addr, ea);
    if (ewe) chk("mem_wdata", mem_wdata, ewd);
    if (ed0) chk("err0", i0.err, ee);
    if (ed1) chk("err1", i1.err, ee);
    if (!reset) begin
      busy = 0;
      last = 1;
      exp_rd0 = 0;
      exp_rd1 = 0;
    end else begin
      if (ewe) ref_mem[ea[5:0]] = ewd;
      if (free) busy = 0;
      if (er0 || er1) begin
        busy = 1;
        g_cyc = cyc;
        g_port = er1;
        last = er1;
        g_write = er1 ? i1.write : i0.write;
        g_addr = er1 ? i1.addr : i0.addr;
        g_wdata = er1 ? i1.wdata : i0.wdata;
        g_bad = is_bad(g_addr);
      end
    end
  end

  task automatic drive(input bit p, input bit v, input bit w, input logic [31:0] a, input logic [31:0] dat);
    if (p) begin
      i1.valid = v; i1.write = w; i1.addr = a; i1.wdata = dat;
    end else begin
      i0.valid = v; i0.write = w; i0.addr = a; i0.wdata = dat;
    end
  endtask

  task automatic req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] dat,
                     output logic [31:0] rd, output bit er, output int lat, output int wt);
    int t;
    bit got;
    rd = 0; er = 0; lat = -1; wt = -1; got = 0; t = 0;
    @(posedge clk); #1;
    drive(p, 1, w, a, dat);
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (p ? i1.ready : i0.ready) begin got = 1; t = cyc; wt = n; end
    end
    @(posedge clk); #1;
    drive(p, 0, w, a, dat);
    chk("grant_seen", got, 1);
    if (!got) return;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (p ? i1.done : i0.done) begin
        got = 1;
        lat = cyc - t;
        rd = p ? i1.rdata : i0.rdata;
        er = p ? i1.err : i0.err;
      end
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    logic [31:0] rd, exp2, ra;
    logic [7:0] pre [8];
    bit er, got, dn, t0, t1;
    int lat, wt;
    int gp[$];
    int gc[$];
    pre = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h02, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i < 8) ? pre[i] : 8'($urandom);
      ref_mem[i] = mem[i];
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    // basic load
    req(0, 0, 0, 0, rd, er, lat, wt);
    chk("t1_rdata", rd, 32'h96969696);
    chk("t1_err", er, 0);
    chk("t1_lat", lat, 6);
    chk("t1_wait", wt, 0);
    // unaligned load
    req(0, 0, 2, 0, rd, er, lat, wt);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("t2_err", er, 1);
    chk("t2_lat", lat, 2);
    exp2 = 32'h96969696;
`else
    chk("t2_rdata", rd, 32'h96960200);
    chk("t2_err", er, 0);
    exp2 = 32'h96960200;
`endif
    // out of range: err at T+2, rdata untouched
    req(0, 0, 33, 0, rd, er, lat, wt);
    chk("t3_err", er, 1);
    chk("t3_lat", lat, 2);
    chk("t3_rdata", rd, exp2);
    // store on port 1, load back on port 0
    req(1, 1, 4, 32'hDEADBEEF, rd, er, lat, wt);
    chk("t4_werr", er, 0);
    chk("t4_wlat", lat, 6);
    req(0, 0, 4, 0, rd, er, lat, wt);
    chk("t4_rdata", rd, 32'hDEADBEEF);
    chk("t4_mem7", mem[7], 8'hEF);
    // both ports valid from the first cycle after reset
    @(posedge clk); #1;
    reset = 0;
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 4, 0);
    @(posedge clk); #1;
    reset = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (i0.ready) begin gp.push_back(0); gc.push_back(cyc); end
      if (i1.ready) begin gp.push_back(1); gc.push_back(cyc); end
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 4, 0);
    chk("t5_count", gp.size(), 6);
    for (int i = 0; i < 4 && i < gp.size(); i++) chk("t5_port", gp[i], i % 2);
    for (int i = 1; i < 4 && i < gc.size(); i++) chk("t5_gap", gc[i] - gc[i-1], 7);
    // reset in the middle of a store
    @(posedge clk); #1;
    drive(0, 1, 1, 0, 32'h11223344);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (i0.ready) got = 1;
    end
    chk("t6_grant", got, 1);
    @(posedge clk); #1;
    drive(0, 0, 1, 0, 32'h11223344);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      dn = dn | i0.done;
    end
    chk("t6_nodone", dn, 0);
    chk("t6_mem0", mem[0], 8'h11);
    chk("t6_mem1", mem[1], 8'h96);
    req(1, 0, 0, 0, rd, er, lat, wt);
    chk("t6_wait", wt, 0);
    chk("t6_rdata", rd, 32'h11969696);
    chk("t6_lat", lat, 6);
    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      t0 = i0.ready;
      t1 = i1.ready;
      @(posedge clk); #1;
      reset = $urandom_range(0, 249) != 0;
      for (int p = 0; p < 2; p++) begin
        if (!(p ? i1.valid : i0.valid) || (p ? t1 : t0) || $urandom_range(0, 15) == 0) begin
          ra = ($urandom_range(0, 7) == 0) ? $urandom_range(33, 40) : $urandom_range(0, 32);
          drive(p[0], $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), ra, $urandom);
        end
      end
    end
    @(posedge clk); #1;
    reset = 1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (12) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the byte-wide data memory between two word-level requesters.
- Port 0 is the CPU load/store stage. Port 1 is the loader/debug port.
- Each granted 32-bit access is sequenced as four big-endian byte accesses on a synchronous byte RAM.
- Adds round-robin arbitration, a valid/ready handshake, and range checking in front of the memory array.

Parameters:
- DEPTH, 36, memory size in bytes; the last legal word address is DEPTH-4.
- AW, 32, address width of request and memory ports.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  reset, synchronous, active-low
- req0_valid  input  1  port 0 request pending
- req0_write  input  1  1 = store, 0 = load
- req0_addr  input  AW  byte address of the word
- req0_wdata  input  32  store data
- req0_ready  output  1  request accepted this cycle
- req0_done  output  1  one-cycle completion pulse
- req0_rdata  output  32  load data; valid while req0_done=1, held until the next done
- req0_err  output  1  qualifies req0_done; access rejected
- req1_*  same set as port 0, for port 1
- mem_addr  output  AW  byte address to the RAM
- mem_we  output  1  byte write strobe
- mem_re  output  1  byte read strobe
- mem_wdata  output  8  write byte
- mem_rdata  input  8  read byte, valid one cycle after mem_re

Behaviour:
- Reset, when reset=0 at a clock edge:
  - state=IDLE; all ready/done/err/mem_we/mem_re = 0; rdata = 0; mem_addr = 0; mem_wdata = 0.
  - Round-robin pointer is set to "last grant = port 1", so port 0 wins the first tie.
- Reset mid-operation:
  - The access aborts immediately and no further mem_we is issued.
  - Bytes already written stay written. No done pulse is produced. The requester must reissue.
- States: IDLE, XFER (byte counter 0..3), DRAIN, DONE.
- IDLE:
  - If any valid is high, grant one port. When both are valid, grant the port not granted last.
  - Assert that port's ready in the same cycle (T), combinationally from valid and state.
  - Capture addr, wdata and write on the clock edge ending T.
- Range check at capture:
  - Fails if addr > DEPTH-4, or if the alignment check fails (see Optional Feature).
  - On failure go to DONE with err=1. No mem_re/mem_we is ever issued for the request.
- XFER, cycles T+1..T+4:
  - Issue byte k=0..3 at mem_addr = addr+k.
  - Byte 0 maps to bits 31:24; byte 3 maps to bits 7:0.
  - Writes: mem_we=1, mem_wdata = the corresponding byte.
  - Reads: mem_re=1; the byte issued in cycle c is captured from mem_rdata at the end of cycle c+1.
- DRAIN, cycle T+5: captures the last read byte. Writes also pass through DRAIN so both access types have the same latency.
- DONE, cycle T+6:
  - done=1 for exactly one cycle on the granted port.
  - rdata holds the assembled word for reads; it is unchanged on writes and on errors.
- A rejected request completes with done+err at T+2.
- Return to IDLE after DONE. A new grant is possible in cycle T+7, so throughput is one word per 7 cycles.
- Handshake rules:
  - The requester holds valid and all fields stable until ready.
  - Dropping valid before ready is allowed; the request is simply not taken.
  - ready is never asserted outside IDLE, and never on both ports in the same cycle.
- Address arithmetic: addr+k is computed modulo 2^AW. Wrap cannot occur for legal addresses.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: addr[1:0] != 0 counts as a range-check failure (err=1, no memory access).
- Undefined: unaligned addresses are accepted, and bytes addr..addr+3 are accessed as long as addr <= DEPTH-4.

Test Plan:
- RAM preloaded with bytes 96 96 96 96 02 00 00 00. Port 0 loads addr 0 at T -> req0_ready at T, mem_re T+1..T+4 at addresses 0..3, req0_done at T+6 with rdata=0x96969696, err=0.
- Port 1 stores 0xDEADBEEF to addr 4, then port 0 loads addr 4 -> mem_we bytes DE, AD, BE, EF at addresses 4..7; the load returns 0xDEADBEEF.
- Both valid continuously from the first cycle after reset, loading addr 0 and addr 4 -> grants in order port 0, port 1, port 0, ... one grant every 7 cycles, each done on the correct port.
- Port 0 loads addr 33 (DEPTH=36) -> done+err at T+2, zero mem_re/mem_we, rdata unchanged.
- Port 0 loads addr 2:
  - With DMEM_ALIGN_CHECK_EN: err=1 and no access.
  - Without it: rdata = {mem[2], mem[3], mem[4], mem[5]} = 0x96960200.
- Store to addr 0 with reset=0 asserted at T+2 -> no mem_we from T+2 onward, no done pulse, state IDLE, the next request is granted normally.
